// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and helpers for the byte-serial load/store sequencer.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Number of memory bytes touched by an access size; 0 marks the illegal size 11.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            2'b10:   size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_seq_if.sv
// Core request/response handshake plus byte-wide data memory port of the sequencer.
interface lsu_byte_seq_if #(
    parameter int ADDR_W = 11,
    parameter int XLEN   = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [2:0]        req_funct3_i;
    logic [XLEN-1:0]   req_addr_i;
    logic [XLEN-1:0]   req_wdata_i;
    logic              rsp_valid_o;
    logic [XLEN-1:0]   rsp_rdata_o;
    logic              rsp_err_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_st_data_o;
    logic              mem_st_en_o;
    logic [7:0]        mem_ld_data_i;

    // The sequencer itself: accepts requests, drives the memory port.
    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_ld_data_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               mem_addr_o, mem_st_data_o, mem_st_en_o
    );

    // The core side together with the memory: issues requests, answers reads.
    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_ld_data_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               mem_addr_o, mem_st_data_o, mem_st_en_o
    );
endinterface

// File: rtl/lsu_ld_ext.sv
// Turns the assembled little-endian load word into the architectural result.
module lsu_ld_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] rdata_o
);

    // Sign- or zero-extend the low byte/half; words pass through, illegal codes give 0.
    always_comb begin
        rdata_o = 32'h0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_H:    rdata_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_W:    rdata_o = raw_i;
            F3_BU:   rdata_o = {24'h0, raw_i[7:0]};
            F3_HU:   rdata_o = {16'h0, raw_i[15:0]};
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_byte_seq.sv
// Load/store sequencer: serialises one 32-bit request into little-endian byte accesses.
module lsu_byte_seq
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int XLEN   = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    lsu_byte_seq_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_RESP   = RESP;

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              err_q;

    logic              accept;
    logic              reqErr;
    logic              inAccess;
    logic [2:0]        lastIdx;
    logic [4:0]        byteSel;
    logic [31:0]       extData;

    assign accept   = (state_q == ST_IDLE) && bus.req_valid_i;
    assign inAccess = (state_q == ST_ACCESS);
    assign lastIdx  = size_bytes(funct3_q[1:0]) - 3'd1;
    assign byteSel  = {cnt_q[1:0], 3'b000};

    // Reject anything that cannot be performed as an in-range, naturally aligned access.
    always_comb begin
        reqErr = 1'b0;
        if (bus.req_funct3_i[1:0] == 2'b11)                          reqErr = 1'b1;
        if (bus.req_we_i && bus.req_funct3_i[2])                     reqErr = 1'b1;
        if (bus.req_addr_i[XLEN-1:ADDR_W] != '0)                     reqErr = 1'b1;
        if (bus.req_funct3_i[1:0] == 2'b01 && bus.req_addr_i[0])     reqErr = 1'b1;
        if (bus.req_funct3_i[1:0] == 2'b10 && bus.req_addr_i[1:0] != 2'b00) reqErr = 1'b1;
    end

    // Next state, byte counter and load-byte assembly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    state_d = reqErr ? ST_RESP : ST_ACCESS;
                    cnt_d   = 3'd0;
                    data_d  = '0;
                end
            end
            ST_ACCESS: begin
                if (!we_q) data_d[byteSel +: 8] = bus.mem_ld_data_i;
                if (cnt_q == lastIdx) begin
                    state_d = ST_RESP;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers; reset abandons any sequence in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Capture the request at the accepting edge so later input changes are ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            we_q     <= bus.req_we_i;
            funct3_q <= bus.req_funct3_i;
            addr_q   <= bus.req_addr_i[ADDR_W-1:0];
            wdata_q  <= bus.req_wdata_i;
            err_q    <= reqErr;
        end
    end

    lsu_ld_ext u_ld_ext (
        .funct3_i (funct3_q),
        .raw_i    (data_q),
        .rdata_o  (extData)
    );

    assign bus.req_ready_o   = (state_q == ST_IDLE) && !rst_i;
    assign bus.mem_addr_o    = inAccess ? addr_q + ADDR_W'(cnt_q) : '0;
    assign bus.mem_st_en_o   = inAccess && we_q;
    assign bus.mem_st_data_o = (inAccess && we_q) ? wdata_q[byteSel +: 8] : 8'h00;
    assign bus.rsp_valid_o   = (state_q == ST_RESP);
    assign bus.rsp_err_o     = (state_q == ST_RESP) && err_q;
    assign bus.rsp_rdata_o   = ((state_q == ST_RESP) && !we_q && !err_q) ? extData : '0;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Directed bench for lsu_byte_seq with a byte-array memory model behind the bus.
module tb_lsu_byte_seq;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   stEnCount = 0;
    int   rspCount = 0;

    logic [7:0] mem [0:2047] = '{default: 8'h00};

    lsu_byte_seq_if #(.ADDR_W(11), .XLEN(32)) bus ();

    lsu_byte_seq #(.ADDR_W(11), .XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Combinational read port of the memory model.
    assign bus.mem_ld_data_i = mem[bus.mem_addr_o];

    // Memory write port plus activity counters for store enables and responses.
    always @(posedge clk) begin
        if (bus.mem_st_en_o) begin
            mem[bus.mem_addr_o] <= bus.mem_st_data_o;
            stEnCount <= stEnCount + 1;
        end
        if (bus.rsp_valid_o) rspCount <= rspCount + 1;
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present a request and return #1 after the accepting edge.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit holdValid);
        bit acc;
        @(negedge clk);
        bus.req_we_i     = we;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        bus.req_valid_i  = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready_o) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("accept", {31'h0, acc}, 32'h1);
        @(posedge clk);
        #1;
        if (!holdValid || !acc) bus.req_valid_i = 1'b0;
    endtask

    // Count edges after the accept until the response pulse, then check it lasts one cycle.
    task automatic waitResponse(output int lat, output logic [31:0] rdata, output logic err);
        lat   = -1;
        rdata = 32'h0;
        err   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.rsp_valid_o) begin
                lat   = i;
                rdata = bus.rsp_rdata_o;
                err   = bus.rsp_err_o;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        checkOutput("rspPulse", {31'h0, bus.rsp_valid_o}, 32'h0);
    endtask

    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          base;
    int          rspBase;
    int          readyCycle;

    logic [2:0]  errF3   [5] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100};
    logic        errWe   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] errAddr [5] = '{32'h013, 32'h012, 32'h800, 32'h000, 32'h040};

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'b000;
        bus.req_addr_i   = 32'h0;
        bus.req_wdata_i  = 32'h0;

        // Reset state
        #3;
        checkOutput("rstReady", {31'h0, bus.req_ready_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("idleReady", {31'h0, bus.req_ready_o}, 32'h1);
        checkOutput("idleRsp",   {31'h0, bus.rsp_valid_o}, 32'h0);
        checkOutput("idleStEn",  {31'h0, bus.mem_st_en_o}, 32'h0);
        checkOutput("idleAddr",  {21'h0, bus.mem_addr_o},  32'h0);

        // SW 0x010
        base = stEnCount;
        applyStimulus(1'b1, F3_W, 32'h010, 32'hDEADBEEF, 1'b0);
        waitResponse(lat, rdata, err);
        checkOutput("swLat",   lat, 32'd4);
        checkOutput("swErr",   {31'h0, err}, 32'h0);
        checkOutput("swRdata", rdata, 32'h0);
        checkOutput("swStEn",  stEnCount - base, 32'd4);
        checkOutput("swMem",   {mem[11'h013], mem[11'h012], mem[11'h011], mem[11'h010]}, 32'hDEADBEEF);

        // Loads of the stored word
        applyStimulus(1'b0, F3_B, 32'h011, 32'h0, 1'b0);
        waitResponse(lat, rdata, err);
        checkOutput("lbLat",   lat, 32'd1);
        checkOutput("lbRdata", rdata, 32'hFFFFFFBE);
        applyStimulus(1'b0, F3_BU, 32'h011, 32'h0, 1'b0);
        waitResponse(lat, rdata, err);
        checkOutput("lbuRdata", rdata, 32'h000000BE);
        applyStimulus(1'b0, F3_H, 32'h012, 32'h0, 1'b0);
        waitResponse(lat, rdata, err);
        checkOutput("lhLat",   lat, 32'd2);
        checkOutput("lhRdata", rdata, 32'hFFFFDEAD);
        applyStimulus(1'b0, F3_HU, 32'h012, 32'h0, 1'b0);
        waitResponse(lat, rdata, err);
        checkOutput("lhuRdata", rdata, 32'h0000DEAD);
        applyStimulus(1'b0, F3_W, 32'h010, 32'h0, 1'b0);
        waitResponse(lat, rdata, err);
        checkOutput("lwLat",   lat, 32'd4);
        checkOutput("lwErr",   {31'h0, err}, 32'h0);
        checkOutput("lwRdata", rdata, 32'hDEADBEEF);

        // Rejected requests
        for (int i = 0; i < 5; i++) begin
            base = stEnCount;
            applyStimulus(errWe[i], errF3[i], errAddr[i], 32'h12345678, 1'b0);
            waitResponse(lat, rdata, err);
            checkOutput($sformatf("errLat%0d", i),   lat, 32'd0);
            checkOutput($sformatf("errFlag%0d", i),  {31'h0, err}, 32'h1);
            checkOutput($sformatf("errRdata%0d", i), rdata, 32'h0);
            checkOutput($sformatf("errStEn%0d", i),  stEnCount - base, 32'd0);
        end

        // Last word of memory, no wrap
        applyStimulus(1'b1, F3_W, 32'h7FC, 32'h01020304, 1'b0);
        waitResponse(lat, rdata, err);
        checkOutput("topSwLat", lat, 32'd4);
        checkOutput("topMem",   {mem[11'h7FF], mem[11'h7FE], mem[11'h7FD], mem[11'h7FC]}, 32'h01020304);
        checkOutput("noWrap",   {24'h0, mem[11'h000]}, 32'h0);
        applyStimulus(1'b0, F3_W, 32'h7FC, 32'h0, 1'b0);
        waitResponse(lat, rdata, err);
        checkOutput("topLwRdata", rdata, 32'h01020304);

        // Asynchronous reset in the middle of a store
        applyStimulus(1'b1, F3_W, 32'h020, 32'hAABBCCDD, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("midStEn", {31'h0, bus.mem_st_en_o}, 32'h1);
        rspBase = rspCount;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstStEn",   {31'h0, bus.mem_st_en_o}, 32'h0);
        checkOutput("rstAddr",   {21'h0, bus.mem_addr_o},  32'h0);
        checkOutput("rstStData", {24'h0, bus.mem_st_data_o}, 32'h0);
        checkOutput("rstRsp",    {31'h0, bus.rsp_valid_o}, 32'h0);
        checkOutput("rstRdy",    {31'h0, bus.req_ready_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("relReady", {31'h0, bus.req_ready_o}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstNoRsp", rspCount - rspBase, 32'd0);
        checkOutput("rstMem",   {mem[11'h023], mem[11'h022], mem[11'h021], mem[11'h020]}, 32'h0000CCDD);

        // Back-to-back SB then LBU with valid held high
        rspBase = rspCount;
        applyStimulus(1'b1, F3_B, 32'h030, 32'h000000A5, 1'b1);
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = F3_BU;
        bus.req_addr_i   = 32'h030;
        checkOutput("b2bBusy", {31'h0, bus.req_ready_o}, 32'h0);
        readyCycle = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                readyCycle = k;
                break;
            end
        end
        checkOutput("b2bReadyCycle", readyCycle, 32'd3);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        waitResponse(lat, rdata, err);
        checkOutput("b2bLat",   lat, 32'd1);
        checkOutput("b2bRdata", rdata, 32'h000000A5);
        checkOutput("b2bMem",   {24'h0, mem[11'h030]}, 32'h000000A5);
        checkOutput("b2bRsps",  rspCount - rspBase, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
